rf_access_arbiter: RTL and testbench
====================================

# rf_access_arbiter

Arbiter and sequencer placed between the core datapath and `registerFile`. It shares the single write port (Addr3/dataIn/regWrite) and read port 1 (Addr1/baseAddr) between the core and a debug requester. Debug transactions are multi-cycle, one at a time, and acknowledged by a pulse. An optional starvation guard stalls the core so a debug access always completes.

## Interface
- `STARVE_LIMIT`, default 4: number of denied PEND cycles before a grant is forced (used only with the guard compiled in).
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `core_we` in 1: core writeback enable.
- `core_waddr` in 5: core write address.
- `core_wdata` in 32: core write data.
- `core_raddr1` in 5: core read port 1 address.
- `core_rd1_use` in 1: core needs read port 1 this cycle.
- `core_stall` out 1: core must hold its current operation this cycle.
- `dbg_req` in 1: one-cycle request pulse, accepted only in IDLE.
- `dbg_we` in 1: 1 = write, 0 = read.
- `dbg_addr` in 5: debug register address.
- `dbg_wdata` in 32: debug write data.
- `dbg_busy` out 1: high in every state except IDLE.
- `dbg_ack` out 1: one-cycle completion pulse.
- `dbg_rdata` out 32: captured read data, held until the next read completes.
- `rf_addr1` out 5: to registerFile Addr1.
- `rf_addr3` out 5: to registerFile Addr3.
- `rf_data_in` out 32: to registerFile dataIn.
- `rf_reg_write` out 1: to registerFile regWrite.
- `rf_base_addr` in 32: from registerFile baseAddr.

## Operation
- **IDLE.** On `dbg_req`, latch `dbg_we`, `dbg_addr` and `dbg_wdata` into hold registers, clear the starvation counter, and go to PEND. `dbg_req` is ignored in every other state.
- **PEND, write.** Go to DBG_WR if `core_we`=0. Otherwise increment the counter and stay.
- **PEND, read.** Go to DBG_RD_A if `core_rd1_use`=0. Otherwise increment the counter and stay.
- **DBG_WR.** Drive the write port with the held address and data. `rf_reg_write`=1 unless the held address is 0, which gives no write but still an ack. Next state is DONE.
- **DBG_RD_A.** Drive `rf_addr1` with the held address. Next state is DBG_RD_B.
- **DBG_RD_B.** Keep `rf_addr1` at the held address. Capture `rf_base_addr` into `dbg_rdata` at the end of the cycle. Next state is DONE.
- **DONE.** `dbg_ack`=1 for this cycle. Next state is IDLE.
- **Port ownership.**
  - Outside DBG_WR, the write port passes the core signals through: `rf_reg_write`=`core_we & ~core_stall`.
  - Outside DBG_RD_A and DBG_RD_B, `rf_addr1`=`core_raddr1`.
- **Core stall.**
  - In DBG_WR, `core_stall`=`core_we`.
  - In DBG_RD_A and DBG_RD_B, `core_stall`=`core_rd1_use`.
  - In all other states, `core_stall`=0 (guard-off baseline).
- **Reset values.** State IDLE, counter 0, `dbg_rdata`=0, `dbg_ack`=0, `dbg_busy`=0, `core_stall`=0, `rf_reg_write`=0.
- **Reset during a transaction.** The transaction is abandoned: no ack and no write. `rf_reg_write` is gated low in any cycle where `reset`=1.
- **Counter.** 3 bits wide. It saturates at `STARVE_LIMIT` and never wraps.

## Timing
- **Debug write latency, uncontended:** `dbg_req` in cycle 0, then PEND in cycle 1, DBG_WR in cycle 2 (write lands at the end of cycle 2), DONE in cycle 3 with `dbg_ack`=1.
- **Debug read latency, uncontended:**
  - cycle 1 PEND, cycle 2 DBG_RD_A, cycle 3 DBG_RD_B (capture);
  - cycle 4 DONE: `dbg_ack`=1 and `dbg_rdata` valid.
- `dbg_rdata` is stable from the DONE cycle until the DBG_RD_B cycle of the next read.
- **Simultaneous events.** When `dbg_req` arrives in the same cycle as a core write, the core write proceeds that cycle. Debug only contends from PEND onward.
- **Stall semantics.** `core_stall` is combinational from state and core inputs. The core must not retire a stalled write; the block masks it on the port regardless.

## Configuration
- Macro `RF_ARB_STARVATION_GUARD_EN`.
- **Defined:**
  - In PEND, when counter == `STARVE_LIMIT`, the grant is forced.
  - In that cycle `core_stall`=`core_we` (write) or `core_rd1_use` (read), and the FSM advances to DBG_WR / DBG_RD_A.
  - The maximum PEND dwell is `STARVE_LIMIT`+1 cycles.
- **Undefined:** the counter is not built. PEND waits indefinitely for an idle port, and `core_stall` is never asserted from PEND.

## Test plan
- **Reset values.** Hold `reset` 2 cycles → all outputs at their reset values; `dbg_busy`=0.
- **Uncontended write.** `dbg_req`, `dbg_we`=1, `dbg_addr`=7, `dbg_wdata`=32'hA5A5_0007, `core_we`=0 → `dbg_ack` in cycle 3, RFMem[7]=32'hA5A5_0007, `core_stall` never 1.
- **Uncontended read.** Preload RFMem[10]=32'hCAFEBABE, `dbg_req` read of address 10 → `dbg_ack` in cycle 4, `dbg_rdata`=32'hCAFEBABE.
- **Write to x0.** Debug write to address 0, data 32'hFFFF_FFFF → `rf_reg_write` stays 0, `dbg_ack` still pulses, RFMem[0]=0.
- **Starvation guard (guard on, `STARVE_LIMIT`=4).** `core_we`=1 continuously, debug write to address 15 → `core_stall`=1 in the 5th PEND cycle and in DBG_WR, RFMem[15] holds the debug data, `dbg_ack` pulses.
- **Guard off, same stimulus** → `dbg_busy` stays 1 with no ack.
- **Reset mid-read.** Assert `reset` in DBG_RD_A → next cycle IDLE, no `dbg_ack`, `dbg_rdata` unchanged at 0.

Source files
------------

// File: rtl/rf_access_arbiter.sv
// rf_access_arbiter
// -----------------------------------------------------------------------------
// Sits between the core datapath and registerFile. The core and a debug
// requester share the single write port (Addr3/dataIn/regWrite) and read
// port 1 (Addr1/baseAddr). A debug access runs as a short multi-cycle
// sequence: it waits in PEND until the core leaves the needed port idle,
// then it takes the port and finishes with a one-cycle dbg_ack pulse.
//
// Optional feature, macro RF_ARB_STARVATION_GUARD_EN:
//   When defined, a 3-bit counter tracks denied PEND cycles. When the
//   counter reaches STARVE_LIMIT, the grant is forced and the core is
//   stalled. When undefined, no counter is built and PEND can wait
//   indefinitely.
//
// Handshake: dbg_req is a one-cycle pulse. It is accepted only while
//   dbg_busy=0 (IDLE). dbg_ack marks completion. For reads, dbg_rdata is
//   valid from the ack cycle until the next read captures.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   core_we/waddr/wdata    core writeback request
//   core_raddr1, core_rd1_use  core read port 1 address / use flag
//   core_stall             core must hold its operation this cycle
//   dbg_req/we/addr/wdata  debug request (one transaction at a time)
//   dbg_busy, dbg_ack      sequencer status / completion pulse
//   dbg_rdata              captured debug read data
//   rf_addr1, rf_addr3, rf_data_in, rf_reg_write  to registerFile
//   rf_base_addr           from registerFile (read port 1 data)
//   fsm_state              current sequencer state, for observation
// -----------------------------------------------------------------------------
module rf_access_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_we,
    input  logic [4:0]  core_waddr,
    input  logic [31:0] core_wdata,
    input  logic [4:0]  core_raddr1,
    input  logic        core_rd1_use,
    output logic        core_stall,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [4:0]  dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_busy,
    output logic        dbg_ack,
    output logic [31:0] dbg_rdata,
    output logic [4:0]  rf_addr1,
    output logic [4:0]  rf_addr3,
    output logic [31:0] rf_data_in,
    output logic        rf_reg_write,
    input  logic [31:0] rf_base_addr,
    output logic [2:0]  fsm_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PEND     = 3'd1,
        S_DBG_WR   = 3'd2,
        S_DBG_RD_A = 3'd3,
        S_DBG_RD_B = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t      r_state;
    logic        r_we;
    logic [4:0]  r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_ack;
    logic        r_busy;

    state_t      w_next;
    logic        w_contended;  // core currently wants the port debug needs
    logic        w_force;      // starvation guard overrides the core
    logic        w_grant;

    assign w_contended = r_we ? core_we : core_rd1_use;

`ifdef RF_ARB_STARVATION_GUARD_EN
    logic [2:0] r_cnt;
    assign w_force = (r_cnt == 3'(STARVE_LIMIT));
`else
    logic w_unused_limit;
    assign w_unused_limit = (STARVE_LIMIT != 0);
    assign w_force        = 1'b0;
`endif

    assign w_grant = ~w_contended | w_force;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     w_next = dbg_req ? S_PEND : S_IDLE;
            S_PEND:     if (w_grant) w_next = r_we ? S_DBG_WR : S_DBG_RD_A;
            S_DBG_WR:   w_next = S_DONE;
            S_DBG_RD_A: w_next = S_DBG_RD_B;
            S_DBG_RD_B: w_next = S_DONE;
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // Stall is combinational so the core sees it in the same cycle the
    // port is taken away.
    always_comb begin
        core_stall = 1'b0;
        case (r_state)
            S_PEND:                 core_stall = w_force & w_contended;
            S_DBG_WR:               core_stall = core_we;
            S_DBG_RD_A, S_DBG_RD_B: core_stall = core_rd1_use;
            default:                core_stall = 1'b0;
        endcase
    end

    // Port muxing; regWrite is forced low during reset so an abandoned
    // transaction (or a core write) never lands while reset is asserted.
    always_comb begin
        rf_addr3     = core_waddr;
        rf_data_in   = core_wdata;
        rf_reg_write = core_we & ~core_stall;
        if (r_state == S_DBG_WR) begin
            rf_addr3     = r_addr;
            rf_data_in   = r_wdata;
            rf_reg_write = (r_addr != 5'd0);
        end
        if (reset) rf_reg_write = 1'b0;
    end

    assign rf_addr1 = ((r_state == S_DBG_RD_A) || (r_state == S_DBG_RD_B))
                      ? r_addr : core_raddr1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_addr  <= 5'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ack   <= (w_next == S_DONE);
            r_busy  <= (w_next != S_IDLE);
            if ((r_state == S_IDLE) && dbg_req) begin
                r_we    <= dbg_we;
                r_addr  <= dbg_addr;
                r_wdata <= dbg_wdata;
            end
            if (r_state == S_DBG_RD_B) r_rdata <= rf_base_addr;
        end
    end

`ifdef RF_ARB_STARVATION_GUARD_EN
    // Saturating denied-cycle counter; cleared when a request is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= 3'd0;
        end else if ((r_state == S_IDLE) && dbg_req) begin
            r_cnt <= 3'd0;
        end else if ((r_state == S_PEND) && !w_grant && !w_force) begin
            r_cnt <= r_cnt + 3'd1;
        end
    end
`endif

    assign dbg_ack   = r_ack;
    assign dbg_busy  = r_busy;
    assign dbg_rdata = r_rdata;
    assign fsm_state = r_state;

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Bench for rf_access_arbiter. A small registerFile model sits on the rf_*
// ports. Driver tasks issue debug transactions and push the expected result
// into a queue; a monitor pops on every dbg_ack and compares read data or
// register contents.
module tb_rf_access_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_we;
    logic [4:0]  core_waddr;
    logic [31:0] core_wdata;
    logic [4:0]  core_raddr1;
    logic        core_rd1_use;
    logic        core_stall;
    logic        dbg_req;
    logic        dbg_we;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_busy;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic [4:0]  rf_addr1;
    logic [4:0]  rf_addr3;
    logic [31:0] rf_data_in;
    logic        rf_reg_write;
    logic [31:0] rf_base_addr;
    logic [2:0]  fsm_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    logic [4:0]  exp_addr_q[$];
    logic        exp_rd_q[$];

    rf_access_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .core_we(core_we), .core_waddr(core_waddr), .core_wdata(core_wdata),
        .core_raddr1(core_raddr1), .core_rd1_use(core_rd1_use),
        .core_stall(core_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_busy(dbg_busy), .dbg_ack(dbg_ack),
        .dbg_rdata(dbg_rdata),
        .rf_addr1(rf_addr1), .rf_addr3(rf_addr3), .rf_data_in(rf_data_in),
        .rf_reg_write(rf_reg_write), .rf_base_addr(rf_base_addr),
        .fsm_state(fsm_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- registerFile model ----------------
    logic [31:0] rf_mem [32];
    logic        mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= 32'd0;
            mem_init <= 1'b1;
        end else if (rf_reg_write) begin
            rf_mem[rf_addr3] <= rf_data_in;
        end
    end
    assign rf_base_addr = rf_mem[rf_addr1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (dbg_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ack: got ack at %0t expected none", $time);
            end else begin
                logic [31:0] e;
                logic [4:0]  a;
                logic        rd;
                e  = exp_q.pop_front();
                a  = exp_addr_q.pop_front();
                rd = exp_rd_q.pop_front();
                if (rd) check("rdata", dbg_rdata, e);
                else    check("mem_write", rf_mem[a], e);
            end
        end
    end

    // ---------------- driver ----------------
    // Issues one debug transaction in cycle 0 and follows it to the ack.
    // hold_rd1: core_rd1_use is held high through this cycle number.
    // Stall and regWrite are recorded per cycle (bit n = cycle n).
    task automatic run_txn(input logic we, input logic [4:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_val,
                           input int hold_rd1, input int exp_lat,
                           input logic [15:0] exp_stall, input logic [15:0] exp_wr);
        logic [15:0] stall_seen;
        logic [15:0] wr_seen;
        logic        got_ack;
        int          lat;
        exp_q.push_back(exp_val);
        exp_addr_q.push_back(addr);
        exp_rd_q.push_back(~we);
        @(posedge clk); #1;
        dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
        core_rd1_use = (hold_rd1 > 0);
        @(posedge clk); #1;
        dbg_req = 1'b0; dbg_we = ~we; dbg_addr = ~addr; dbg_wdata = ~wdata;
        core_rd1_use = (hold_rd1 >= 1);
        stall_seen = '0; wr_seen = '0; got_ack = 1'b0; lat = 1;
        while (!got_ack && lat < 40) begin
            @(negedge clk);
            if (lat < 16) begin
                stall_seen[lat] = core_stall;
                wr_seen[lat]    = rf_reg_write;
            end
            if (dbg_ack) got_ack = 1'b1;
            else begin
                @(posedge clk); #1;
                lat++;
                core_rd1_use = (lat <= hold_rd1);
            end
        end
        check("ack_seen", 32'(got_ack), 32'd1);
        check("ack_latency", lat, exp_lat);
        check("stall_pattern", 32'(stall_seen), 32'(exp_stall));
        check("regwrite_pattern", 32'(wr_seen), 32'(exp_wr));
        @(posedge clk); #1;
        @(negedge clk);
        check("ack_one_cycle", 32'(dbg_ack), 32'd0);
        check("busy_after_done", 32'(dbg_busy), 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; core_we = 1'b1; core_waddr = 5'd3; core_wdata = 32'h1234_5678;
        core_raddr1 = 5'd0; core_rd1_use = 1'b0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 5'd0; dbg_wdata = 32'd0;

        // Reset values, with a core write pending to prove regWrite gating.
        repeat (2) begin
            @(negedge clk);
            check("rst_regwrite", 32'(rf_reg_write), 32'd0);
            check("rst_stall", 32'(core_stall), 32'd0);
            check("rst_ack", 32'(dbg_ack), 32'd0);
            check("rst_busy", 32'(dbg_busy), 32'd0);
            check("rst_rdata", dbg_rdata, 32'd0);
            check("rst_state", 32'(fsm_state), 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0; core_waddr = 5'd10; core_wdata = 32'hCAFE_BABE;
        core_raddr1 = 5'd3; core_rd1_use = 1'b1;

        // Core pass-through: preloads RFMem[10].
        @(negedge clk);
        check("core_regwrite", 32'(rf_reg_write), 32'd1);
        check("core_addr3", 32'(rf_addr3), 32'd10);
        check("core_data_in", rf_data_in, 32'hCAFE_BABE);
        check("core_addr1", 32'(rf_addr1), 32'd3);
        check("core_no_stall", 32'(core_stall), 32'd0);
        @(posedge clk); #1;
        core_we = 1'b0; core_rd1_use = 1'b0;

        // Reset during DBG_RD_A: abandoned, no ack, rdata stays 0.
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd10;
        @(posedge clk); #1;
        dbg_req = 1'b0;
        @(negedge clk);
        check("mid_pend_busy", 32'(dbg_busy), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("mid_rda_state", 32'(fsm_state), 32'd3);
        check("mid_rda_addr1", 32'(rf_addr1), 32'd10);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("mid_state_idle", 32'(fsm_state), 32'd0);
        check("mid_no_ack", 32'(dbg_ack), 32'd0);
        check("mid_busy", 32'(dbg_busy), 32'd0);
        check("mid_rdata", dbg_rdata, 32'd0);
        repeat (3) @(posedge clk);

        // Uncontended read of 10: ack in cycle 4.
        run_txn(1'b0, 5'd10, 32'h0, 32'hCAFE_BABE, 0, 4, 16'h0000, 16'h0000);
        // Uncontended write of 7: regWrite in cycle 2, ack in cycle 3.
        run_txn(1'b1, 5'd7, 32'hA5A5_0007, 32'hA5A5_0007, 0, 3, 16'h0000, 16'h0004);
        check("rdata_held", dbg_rdata, 32'hCAFE_BABE);
        // Write to x0: no regWrite, ack still pulses.
        run_txn(1'b1, 5'd0, 32'hFFFF_FFFF, 32'h0, 0, 3, 16'h0000, 16'h0000);
        // Read of 7 with core holding read port 1 for two PEND cycles.
        run_txn(1'b0, 5'd7, 32'h0, 32'hA5A5_0007, 2, 6, 16'h0000, 16'h0000);

        // Core writes every cycle; debug write to 15.
        core_we = 1'b1; core_waddr = 5'd20; core_wdata = 32'h1111_2222;
`ifdef RF_ARB_STARVATION_GUARD_EN
        // Forced grant in the 5th PEND cycle (cycle 5), DBG_WR in cycle 6.
        run_txn(1'b1, 5'd15, 32'h0F0F_0015, 32'h0F0F_0015, 0, 7, 16'h0060, 16'h00DE);
        core_we = 1'b0;
`else
        @(posedge clk); #1;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd15; dbg_wdata = 32'h0F0F_0015;
        @(posedge clk); #1;
        dbg_req = 1'b0;
        begin
            logic any_ack;
            logic any_stall;
            logic all_busy;
            any_ack = 1'b0; any_stall = 1'b0; all_busy = 1'b1;
            repeat (20) begin
                @(negedge clk);
                any_ack   |= dbg_ack;
                any_stall |= core_stall;
                all_busy  &= dbg_busy;
                @(posedge clk); #1;
            end
            check("starve_no_ack", 32'(any_ack), 32'd0);
            check("starve_no_stall", 32'(any_stall), 32'd0);
            check("starve_busy", 32'(all_busy), 32'd1);
            check("starve_state_pend", 32'(fsm_state), 32'd1);
            check("starve_mem15", rf_mem[15], 32'd0);
        end
        core_we = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("starve_reset_idle", 32'(fsm_state), 32'd0);
`endif
        check("core_mem20", rf_mem[20], 32'h1111_2222);

        repeat (4) @(posedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
